// File: rtl/period_pkg.sv
// Shared definitions for the period averaging path: clock rate, default
// acceptance limits and the tracking state encoding.
package period_pkg;

    localparam int unsigned CLK_HZ          = 100_000_000;
    localparam int unsigned DEF_MIN_PERIOD  = CLK_HZ / 1000;   // 1 kHz
    localparam int unsigned DEF_MAX_PERIOD  = CLK_HZ / 10;     // 10 Hz
    localparam int unsigned DEF_TIMEOUT_CYC = CLK_HZ / 5;      // 200 ms of silence

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOST   = 2'd2
    } state_e;

endpackage

// File: rtl/period_avg_filter_if.sv
// Sample input and statistics output bundle between the period measurement
// stage (master) and the averaging filter (slave).
interface period_avg_filter_if;

    logic               clear;
    logic               in_valid;
    logic [31:0]        in_period;
    logic               out_valid;
    logic [31:0]        avg_period;
    logic signed [31:0] jitter;
    logic [31:0]        min_period;
    logic [31:0]        max_period;
    logic               range_err;
    logic [15:0]        err_cnt;
    logic               signal_lost;
    logic               locked;

    modport master (
        output clear, in_valid, in_period,
        input  out_valid, avg_period, jitter, min_period, max_period,
               range_err, err_cnt, signal_lost, locked
    );

    modport slave (
        input  clear, in_valid, in_period,
        output out_valid, avg_period, jitter, min_period, max_period,
               range_err, err_cnt, signal_lost, locked
    );

endinterface

// File: rtl/period_ring_buf.sv
// Window storage of the last 2^LOG2_N accepted periods; the entry about to be
// overwritten is exposed combinationally so the running sum can subtract it.
module period_ring_buf #(
    parameter int LOG2_N = 3,
    parameter int W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [W-1:0]    wr_data,
    output logic [W-1:0]    evicted,
    output logic [LOG2_N:0] fill
);

    logic [W-1:0]        mem [1 << LOG2_N];
    logic [LOG2_N-1:0]   wptr;

    assign evicted = mem[wptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    // fill saturates at N; its top bit doubles as the window-full flag
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            fill <= '0;
        end else if (wr_en) begin
            wptr <= wptr + 1'b1;
            if (!fill[LOG2_N]) fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/period_avg_filter.sv
// Range-checks period samples, keeps a sliding-window average, jitter and
// min/max, and declares the input lost after a silence timeout.
module period_avg_filter
    import period_pkg::*;
#(
    parameter int          LOG2_N      = 3,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned MAX_PERIOD  = DEF_MAX_PERIOD,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    period_avg_filter_if.slave bus
);

    localparam int N      = 1 << LOG2_N;
    localparam int SW     = 32 + LOG2_N;
    localparam int STAGES = 1;

    state_e             state;
    logic [SW-1:0]      sum;
    logic [31:0]        idle, prev, min_r, max_r, avg_r;
    logic signed [31:0] jitter_r;
    logic               have_prev, range_err_r;
    logic [15:0]        err_cnt_r;
    logic [STAGES:0]    vld_pipe;

    logic               in_rng, accept, reject, timeout, flush, full, to_track;
    logic [LOG2_N:0]    fill;
    logic [31:0]        evicted;
    logic [SW-1:0]      sum_nxt;

    assign in_rng   = (bus.in_period >= MIN_PERIOD) && (bus.in_period <= MAX_PERIOD);
    assign accept   = bus.in_valid && !bus.clear && in_rng;
    assign reject   = bus.in_valid && !bus.clear && !in_rng;
    assign timeout  = !bus.in_valid && !bus.clear && (idle == TIMEOUT_CYC - 1);
    assign flush    = bus.clear || timeout;
    assign full     = fill[LOG2_N];
    assign to_track = full || (fill == (LOG2_N+1)'(N - 1));
    assign sum_nxt  = sum + SW'(bus.in_period) - (full ? SW'(evicted) : '0);

    period_ring_buf #(.LOG2_N(LOG2_N), .W(32)) u_ring (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (accept),
        .wr_data (bus.in_period),
        .evicted (evicted),
        .fill    (fill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_WARMUP;
            sum         <= '0;
            idle        <= '0;
            prev        <= '0;
            have_prev   <= 1'b0;
            vld_pipe    <= '0;
            avg_r       <= '0;
            jitter_r    <= '0;
            min_r       <= '1;
            max_r       <= '0;
            range_err_r <= 1'b0;
            err_cnt_r   <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[STAGES-1:0], accept && to_track};
            range_err_r <= reject;
            // the timer parks at its limit so LOST is held until a sample arrives
            if (bus.in_valid || bus.clear) idle <= '0;
            else if (!timeout)             idle <= idle + 32'd1;

            if (bus.clear)                             err_cnt_r <= '0;
            else if (reject && err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;

            if (flush) begin
                state     <= bus.clear ? ST_WARMUP : ST_LOST;
                sum       <= '0;
                min_r     <= '1;
                max_r     <= '0;
                have_prev <= 1'b0;
            end else if (accept) begin
                state     <= to_track ? ST_TRACK : ST_WARMUP;
                sum       <= sum_nxt;
                jitter_r  <= have_prev ? $signed(bus.in_period - prev) : '0;
                prev      <= bus.in_period;
                have_prev <= 1'b1;
                if (bus.in_period < min_r) min_r <= bus.in_period;
                if (bus.in_period > max_r) max_r <= bus.in_period;
            end

            if (vld_pipe[0]) avg_r <= 32'(sum >> LOG2_N);
        end
    end

    assign bus.out_valid   = vld_pipe[STAGES];
    assign bus.avg_period  = avg_r;
    assign bus.jitter      = jitter_r;
    assign bus.min_period  = min_r;
    assign bus.max_period  = max_r;
    assign bus.range_err   = range_err_r;
    assign bus.err_cnt     = err_cnt_r;
    assign bus.signal_lost = (state == ST_LOST);
    assign bus.locked      = (state == ST_TRACK);

endmodule

// File: tb/tb_period_avg_filter.sv
// Directed plus randomized bench for period_avg_filter against a queue-based
// model of the sliding window and its statistics.
module tb_period_avg_filter;

    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;
    localparam int MINP   = 100000;
    localparam int MAXP   = 10000000;
    localparam int TMO    = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    period_avg_filter_if bus();

    period_avg_filter #(
        .LOG2_N(LOG2_N), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]        m_win[$];
    bit                 m_locked, m_lost, m_have_prev, m_rerr, m_ov;
    logic [31:0]        m_min, m_max, m_prev, m_avg;
    logic signed [31:0] m_jit;
    logic [15:0]        m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_flush(input bit by_clear);
        m_win.delete();
        m_locked    = 0;
        m_lost      = !by_clear;
        m_min       = 32'hFFFFFFFF;
        m_max       = 0;
        m_have_prev = 0;
        m_rerr      = 0;
        m_ov        = 0;
        if (by_clear) m_err = 0;
    endtask

    task automatic model_reset();
        model_flush(1);
        m_lost = 0;
        m_avg  = 0;
        m_jit  = 0;
        m_prev = 0;
    endtask

    task automatic model_sample(input logic [31:0] p);
        logic [63:0] s;
        m_rerr = 0;
        m_ov   = 0;
        if (p < MINP || p > MAXP) begin
            m_rerr = 1;
            if (m_err != 16'hFFFF) m_err++;
            return;
        end
        m_lost      = 0;
        m_jit       = m_have_prev ? $signed(p - m_prev) : 32'sd0;
        m_prev      = p;
        m_have_prev = 1;
        if (p < m_min) m_min = p;
        if (p > m_max) m_max = p;
        m_win.push_back(p);
        if (m_win.size() > N) void'(m_win.pop_front());
        m_locked = (m_win.size() == N);
        m_ov     = m_locked;
        if (m_ov) begin
            s = 0;
            foreach (m_win[i]) s += 64'(m_win[i]);
            m_avg = 32'(s / N);
        end
    endtask

    task automatic check_stat(input string tag);
        chk({tag, ".range_err"}, 64'(bus.range_err), 64'(m_rerr));
        chk({tag, ".locked"},    64'(bus.locked), 64'(m_locked));
        chk({tag, ".lost"},      64'(bus.signal_lost), 64'(m_lost));
        chk({tag, ".min"},       64'(bus.min_period), 64'(m_min));
        chk({tag, ".max"},       64'(bus.max_period), 64'(m_max));
        chk({tag, ".jitter"},    64'(bus.jitter), 64'(m_jit));
        chk({tag, ".err_cnt"},   64'(bus.err_cnt), 64'(m_err));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, ".avg"},       64'(bus.avg_period), 64'(0));
        chk({tag, ".jitter"},    64'(bus.jitter), 64'(0));
        chk({tag, ".min"},       64'(bus.min_period), 64'(32'hFFFFFFFF));
        chk({tag, ".max"},       64'(bus.max_period), 64'(0));
        chk({tag, ".range_err"}, 64'(bus.range_err), 64'(0));
        chk({tag, ".err_cnt"},   64'(bus.err_cnt), 64'(0));
        chk({tag, ".lost"},      64'(bus.signal_lost), 64'(0));
        chk({tag, ".locked"},    64'(bus.locked), 64'(0));
    endtask

    // one isolated sample: statistics one cycle later, strobe/avg two cycles later
    task automatic send(input logic [31:0] p, input string tag);
        @(negedge clk);
        bus.in_valid  = 1;
        bus.in_period = p;
        @(negedge clk);
        bus.in_valid = 0;
        model_sample(p);
        check_stat(tag);
        @(negedge clk);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_ov));
        chk({tag, ".avg"},       64'(bus.avg_period), 64'(m_avg));
    endtask

    task automatic burst(input logic [31:0] base, input logic [31:0] step, input string tag);
        bit          ovq[$];
        logic [31:0] avq[$];
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= N) begin
                model_sample(base + step * (i - 1));
                check_stat(tag);
                ovq.push_back(m_ov);
                avq.push_back(m_avg);
            end
            if (i >= 2) begin
                chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ovq[i-2]));
                chk({tag, ".avg"},       64'(bus.avg_period), 64'(avq[i-2]));
            end
            if (i < N) begin
                bus.in_valid  = 1;
                bus.in_period = base + step * i;
            end else begin
                bus.in_valid = 0;
            end
        end
    endtask

    initial begin
        logic [31:0] p;
        rst           = 1;
        bus.clear     = 0;
        bus.in_valid  = 0;
        bus.in_period = 0;
        repeat (3) @(negedge clk);
        model_reset();
        check_reset("reset");
        rst = 0;

        for (int i = 0; i < N; i++) send(32'd100000, "warm");
        chk("warm.avg_abs", 64'(bus.avg_period), 64'(100000));

        send(32'd100800, "slide");
        chk("slide.avg_abs", 64'(bus.avg_period), 64'(100100));
        chk("slide.jit_abs", 64'(bus.jitter), 64'(32'sd800));
        send(32'd100000, "slide2");
        chk("slide2.jit_abs", 64'(bus.jitter), 64'(-32'sd800));
        chk("slide2.max_abs", 64'(bus.max_period), 64'(100800));

        send(32'd50000, "rej_lo");
        send(32'd10000001, "rej_hi");
        chk("rej.err_abs", 64'(bus.err_cnt), 64'(2));
        send(32'd10000000, "edge_hi");
        send(32'd100000, "edge_lo");
        send(32'd99999, "edge_lo_m1");

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 9))
                0:       p = $urandom_range(0, MINP - 1);
                1:       p = $urandom_range(MAXP + 1, 32'hFFFF_FFFF);
                default: p = $urandom_range(MINP, MAXP);
            endcase
            send(p, "rand");
        end

        // silence: LOST lands exactly TMO edges after the last sample
        repeat (TMO - 2) @(negedge clk);
        chk("tmo.early", 64'(bus.signal_lost), 64'(0));
        @(negedge clk);
        model_flush(0);
        check_stat("tmo");
        chk("tmo.avg_hold", 64'(bus.avg_period), 64'(m_avg));

        send(32'd200000, "relock");
        chk("relock.jit_abs", 64'(bus.jitter), 64'(0));
        for (int i = 0; i < N; i++) send($urandom_range(MINP, 2 * MINP), "refill");

        @(negedge clk);
        bus.clear     = 1;
        bus.in_valid  = 1;
        bus.in_period = 150000;
        @(negedge clk);
        bus.clear    = 0;
        bus.in_valid = 0;
        model_flush(1);
        check_stat("clr");
        @(negedge clk);
        chk("clr.out_valid", 64'(bus.out_valid), 64'(0));
        for (int i = 0; i < N; i++) send($urandom_range(MINP, MAXP), "post_clr");

        burst(32'd300000, 32'd1000, "b2b");
        burst(32'd9000000, 32'd100000, "b2b_wrap");

        @(negedge clk);
        bus.in_valid  = 1;
        bus.in_period = 120000;
        @(negedge clk);
        bus.in_period = 130000;
        rst           = 1;
        @(negedge clk);
        bus.in_valid = 0;
        model_reset();
        check_reset("rst_mid");
        rst = 0;
        for (int i = 0; i < N; i++) send(32'd100000 + 32'(i), "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
